// File: rtl/dm_store_pkg.sv
// Shared CPU store definitions: op encodings, byte-enable constants and the
// store-buffer entry layout used by the store and load-extension paths.
package dm_store_pkg;

  typedef enum logic [1:0] {
    OP_SW   = 2'b00,
    OP_SB   = 2'b01,
    OP_SH   = 2'b10,
    OP_RSVD = 2'b11
  } store_op_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_entry_t;

endpackage

// File: rtl/dm_store_if.sv
// Request bus from the MEM stage and write bus toward data memory.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid && ready; valid must not depend on ready, and payload holds while valid && !ready.
interface dm_store_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport master (
    output req_valid, req_op, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_align.sv
// Combinational store lane alignment: legality check, lane replication and
// byte enables for sw/sh/sb.
module store_align
  import dm_store_pkg::*;
(
  input  logic [1:0]   op,
  input  logic [31:0]  addr,
  input  logic [31:0]  data,
  output logic         legal,
  output store_entry_t entry
);

  always_comb begin
    legal       = 1'b0;
    entry.addr  = {addr[31:2], 2'b00};
    entry.wdata = data;
    entry.be    = BE_WORD;
    case (store_op_e'(op))
      OP_SW: legal = (addr[1:0] == 2'b00);
      OP_SB: begin
        legal       = 1'b1;
        entry.wdata = {4{data[7:0]}};
        entry.be    = BE_BYTE0 << addr[1:0];
      end
      OP_SH: begin
        legal       = !addr[0];
        entry.wdata = {2{data[15:0]}};
        entry.be    = addr[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_store.sv
// Store buffer between the MEM stage and data memory: FIFO of aligned stores,
// misalignment exception flag and a pending-store word-address hit check.
module dm_store
  import dm_store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  dm_store_if.slave   bus,
  output logic        exc,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  store_entry_t      ent_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              exc_q;

  logic              legal;
  store_entry_t      new_ent;
  logic              full, req_fire, enq, deq, hit;

  store_align u_align (
    .op    (bus.req_op),
    .addr  (bus.req_addr),
    .data  (bus.req_data),
    .legal (legal),
    .entry (new_ent)
  );

  // Readiness comes only from registered count so a same-cycle drain never
  // opens a slot early.
  assign full          = (count == (PW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign bus.req_ready = !full;
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign enq           = req_fire && legal;
  assign deq           = bus.mem_valid && bus.mem_ready;

  assign bus.mem_valid = !empty;
  assign bus.mem_addr  = ent_q[rd_ptr].addr;
  assign bus.mem_wdata = ent_q[rd_ptr].wdata;
  assign bus.mem_be    = ent_q[rd_ptr].be;
  assign exc           = exc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      exc_q  <= 1'b0;
    end else begin
      exc_q <= req_fire && !legal;
      if (deq) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (enq) begin
        ent_q[wr_ptr] <= new_ent;
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Stored addresses already have bits [1:0] cleared; only the word index matters.
  wire unused_chk_low = ^chk_addr[1:0];

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_q[i].addr[31:2] == chk_addr[31:2])) hit = 1'b1;
    end
  end

  assign chk_hit = hit;

endmodule

// File: tb/tb_dm_store.sv
// Directed bench for dm_store (DEPTH=2): alignment cases, backpressure,
// FIFO order, hit check and asynchronous reset mid-drain.
module tb_dm_store;
  import dm_store_pkg::*;

  logic        clk;
  logic        reset;
  logic        exc;
  logic [31:0] chk_addr;
  logic        chk_hit;
  logic        empty;

  dm_store_if bus ();

  dm_store #(.DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .exc      (exc),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .empty    (empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [67:0] exp_q[$];

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] head();
    return {bus.mem_addr, bus.mem_wdata, bus.mem_be};
  endfunction

  // Advance one clock; any memory handshake at that edge is scored against exp_q.
  task automatic cyc();
    logic [67:0] e;
    if (bus.mem_valid && bus.mem_ready) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_deq: got %h want none", head());
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("deq", head(), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  initial begin
    reset         = 1'b1;
    chk_addr      = 32'h0;
    bus.mem_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_empty",     empty, 1);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_chk_hit",   chk_hit, 0);
    chk("rst_exc",       exc, 0);
    chk("rst_head",      head(), 68'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // sb at byte 3
    bus.mem_ready = 1'b1;
    drive(1'b1, OP_SB, 32'h0000_1003, 32'h0000_00AB);
    exp_q.push_back({32'h0000_1000, 32'hABAB_ABAB, 4'b1000});
    #1;
    chk("sb_ready", bus.req_ready, 1);
    chk("lat_before", bus.mem_valid, 0);
    cyc();
    drive(1'b0, OP_SW, 32'h0, 32'h0);
    chk_addr = 32'h0000_1001;
    #1;
    chk("sb_head", head(), {32'h0000_1000, 32'hABAB_ABAB, 4'b1000});
    chk("sb_valid", bus.mem_valid, 1);
    chk("sb_hit", chk_hit, 1);
    chk("sb_exc", exc, 0);
    cyc();
    chk("sb_drained", empty, 1);

    // sh upper half, then misaligned sh
    drive(1'b1, OP_SH, 32'h0000_2002, 32'h1234_BEEF);
    exp_q.push_back({32'h0000_2000, 32'hBEEF_BEEF, 4'b1100});
    cyc();
    drive(1'b1, OP_SH, 32'h0000_2001, 32'h0000_5555);
    #1;
    chk("sh_head", head(), {32'h0000_2000, 32'hBEEF_BEEF, 4'b1100});
    cyc();
    drive(1'b0, OP_SW, 32'h0, 32'h0);
    #1;
    chk("sh_mis_exc", exc, 1);
    chk("sh_mis_empty", empty, 1);
    cyc();
    chk("sh_exc_one_cycle", exc, 0);
    chk("sh_empty_after", empty, 1);

    // reserved op and misaligned sw
    drive(1'b1, OP_RSVD, 32'h0000_0010, 32'hFFFF_FFFF);
    cyc();
    drive(1'b1, OP_SW, 32'h0000_4002, 32'h0000_0001);
    #1;
    chk("rsvd_exc", exc, 1);
    chk("rsvd_empty", empty, 1);
    cyc();
    drive(1'b0, OP_SW, 32'h0, 32'h0);
    #1;
    chk("sw_mis_exc", exc, 1);
    chk("sw_mis_empty", empty, 1);
    cyc();
    chk("sw_mis_clear", exc, 0);

    // backpressure: fill, stall, drain with simultaneous enqueue
    bus.mem_ready = 1'b0;
    chk_addr = 32'h0000_3002;
    drive(1'b1, OP_SW, 32'h0000_3000, 32'h1111_1111);
    cyc();
    drive(1'b1, OP_SW, 32'h0000_3004, 32'h2222_2222);
    #1;
    chk("bp_head1", head(), {32'h0000_3000, 32'h1111_1111, 4'b1111});
    chk("bp_ready1", bus.req_ready, 1);
    chk("bp_hit", chk_hit, 1);
    cyc();
    drive(1'b1, OP_SW, 32'h0000_3008, 32'h3333_3333);
    #1;
    chk("bp_full_ready", bus.req_ready, 0);
    chk("bp_empty", empty, 0);
    cyc();
    chk("bp_stall_head", head(), {32'h0000_3000, 32'h1111_1111, 4'b1111});
    chk("bp_stall_ready", bus.req_ready, 0);
    bus.mem_ready = 1'b1;
    exp_q.push_back({32'h0000_3000, 32'h1111_1111, 4'b1111});
    exp_q.push_back({32'h0000_3004, 32'h2222_2222, 4'b1111});
    exp_q.push_back({32'h0000_3008, 32'h3333_3333, 4'b1111});
    #1;
    chk("full_deq_ready", bus.req_ready, 0);
    cyc();
    chk("after_deq_ready", bus.req_ready, 1);
    chk("after_deq_head", head(), {32'h0000_3004, 32'h2222_2222, 4'b1111});
    chk("after_deq_hit", chk_hit, 0);
    cyc();
    drive(1'b0, OP_SW, 32'h0, 32'h0);
    chk_addr = 32'h0000_3008;
    #1;
    chk("wrap_head", head(), {32'h0000_3008, 32'h3333_3333, 4'b1111});
    chk("wrap_ready", bus.req_ready, 1);
    chk("wrap_hit", chk_hit, 1);
    cyc();
    chk("drain_empty", empty, 1);
    chk("drain_hit", chk_hit, 0);

    // reset with two pending entries
    bus.mem_ready = 1'b0;
    chk_addr = 32'h0000_5000;
    drive(1'b1, OP_SW, 32'h0000_5000, 32'hAAAA_0000);
    cyc();
    drive(1'b1, OP_SW, 32'h0000_5004, 32'hAAAA_0004);
    cyc();
    drive(1'b0, OP_SW, 32'h0, 32'h0);
    #1;
    chk("pre_rst_full", bus.req_ready, 0);
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("arst_mem_valid", bus.mem_valid, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ready", bus.req_ready, 1);
    chk("arst_hit", chk_hit, 0);
    chk("arst_head", head(), 68'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc();
    cyc();
    chk("post_rst_valid", bus.mem_valid, 0);
    chk("post_rst_empty", empty, 1);
    chk("exp_q_empty", 68'(exp_q.size()), 68'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_store.md
DM_STORE -- requirements
Module: dm_store

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of store-buffer entries (power of two, >=2).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be asynchronous and active-high.
REQ-004 req_valid  in  1  store request presented by pipeline MEM stage.
REQ-005 req_ready  out  1  buffer can accept a request.
REQ-006 req_op  in  2  SHALL encode 00 sw, 01 sb, 10 sh, 11 reserved.
REQ-007 req_addr  in  32  byte address of store.
REQ-008 req_data  in  32  unaligned register data (rt).
REQ-009 exc  out  1  one-cycle misaligned/illegal-store flag.
REQ-010 mem_valid  out  1  head entry valid toward data memory.
REQ-011 mem_ready  in  1  data memory accepts head entry.
REQ-012 mem_addr  out  32  word address, bits [1:0] SHALL be 0.
REQ-013 mem_wdata  out  32  lane-aligned write data.
REQ-014 mem_be  out  4  byte enables, bit i = byte lane i (bits [8i+7:8i]).
REQ-015 chk_addr  in  32  load address to test against pending stores.
REQ-016 chk_hit  out  1  a pending store covers chk_addr's word.
REQ-017 empty  out  1  no valid entries.

Function
REQ-018 Handshake SHALL occur when req_valid && req_ready; req_ready SHALL equal !full from registered state only (no same-cycle bypass through a dequeue).
REQ-019 Alignment: sw SHALL require addr[1:0]=00; sh addr[0]=0; sb any; op 11 always illegal.
REQ-020 Illegal/misaligned handshake SHALL NOT enqueue and SHALL raise exc for exactly the following cycle.
REQ-021 sb SHALL enqueue wdata={4{data[7:0]}}, be=0001<<addr[1:0].
REQ-022 sh SHALL enqueue wdata={2{data[15:0]}}, be=addr[1]?1100:0011.
REQ-023 sw SHALL enqueue wdata=data, be=1111.
REQ-024 Enqueued mem_addr SHALL be {addr[31:2],2'b00}.
REQ-025 Latency: an entry accepted in cycle N SHALL be visible on mem_valid no earlier than cycle N+1.
REQ-026 mem_valid SHALL equal !empty; head fields SHALL hold stable while mem_valid && !mem_ready.
REQ-027 Dequeue SHALL occur on mem_valid && mem_ready; entries SHALL drain in FIFO order.
REQ-028 Simultaneous enqueue and dequeue SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-029 When full, req_ready SHALL be 0 even if mem_ready is 1 that cycle.
REQ-030 chk_hit SHALL be combinational: 1 iff any valid entry's addr[31:2] equals chk_addr[31:2]; 0 when empty.
REQ-031 No entry SHALL ever be dropped or duplicated; count SHALL stay within 0..DEPTH.

Reset
REQ-032 Asserting reset SHALL immediately clear count, pointers, entry valid bits and exc; mem_valid=0, empty=1, req_ready=1, chk_hit=0.
REQ-033 Entry data/be/addr registers SHALL reset to 0, so mem_addr/mem_wdata/mem_be read 0 during reset.
REQ-034 Reset mid-drain SHALL discard all pending entries; an in-flight mem handshake that cycle is lost.

Structure
REQ-035 Op codes (SW/SB/SH) and byte-enable constants SHALL live in the shared CPU package used with the load-extension logic.
REQ-036 Lane alignment (REQ-019..REQ-024) SHALL be a combinational sub-module store_align; dm_store holds buffer, pointers, handshake and hit logic.

Verification
REQ-037 sb addr=0x1003 data=0x000000AB, mem_ready=1 -> next cycle mem_addr=0x1000 wdata=0xABABABAB be=1000.
REQ-038 sh addr=0x2002 data=0x1234BEEF -> wdata=0xBEEFBEEF be=1100; sh addr=0x2001 -> exc=1 one cycle, empty stays 1.
REQ-039 mem_ready=0, three sw (DEPTH=2) -> first two accepted, req_ready=0 on third; raise mem_ready -> drain in order, third then accepted.
REQ-040 sw 0x3000 pending, chk_addr=0x3002 -> chk_hit=1; after drain -> chk_hit=0.
REQ-041 Full buffer with mem_ready=1 and req_valid=1 -> one dequeue, no enqueue that cycle; next cycle enqueue succeeds.
REQ-042 Reset asserted with 2 entries pending -> mem_valid=0, empty=1 asynchronously; no further mem handshakes after release.
